adder_rr_sched: RTL

- Round-robin scheduler sharing one adder datapath (4-bit a/b, valid strobe, 7-bit registered result c, one-cycle latency) between NUM_REQ requesters.
- Arbitrates, latches the winner's operands, strobes the adder, captures the result and returns it to the winner with a one-cycle response pulse.
- Sits between requester clients and the single adder instance.

---
 rtl/adder_rr_sched.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/adder_rr_sched.sv
// adder_rr_sched: round-robin scheduler sharing one registered adder between NUM_REQ requesters.
// Latency: req seen in IDLE at cycle t gives a rsp_valid pulse at t+3; one operation every 4 cycles.
// Backpressure: requesters hold req until their rsp_valid pulse, and losing requesters just wait.
// Optional macro ADDER_RR_SCHED_PRIO0_EN gives requester 0 strict priority without moving the pointer.
module adder_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int A_W     = 4,
  parameter int C_W     = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*A_W-1:0] req_b,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [C_W-1:0]         rsp_data,
  output logic                   add_valid,
  output logic [A_W-1:0]         add_a,
  output logic [A_W-1:0]         add_b,
  input  logic [C_W-1:0]         add_c,
  output logic                   busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_win;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [C_W-1:0]     r_rsp_data;
  logic               r_add_valid;
  logic [A_W-1:0]     r_add_a;
  logic [A_W-1:0]     r_add_b;
  logic               r_busy;

  logic               w_found;
  logic [PTR_W-1:0]   w_win;
  logic [PTR_W-1:0]   w_idx;
  logic [NUM_REQ-1:0] w_win_oh;
  logic [A_W-1:0]     w_a;
  logic [A_W-1:0]     w_b;
  logic [PTR_W-1:0]   w_ptr_nxt;

  // Winner search: first set req at or after the pointer, wrapping modulo NUM_REQ
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
`ifdef ADDER_RR_SCHED_PRIO0_EN
    // Requester 0 overrides the rotation whenever it asks
    if (req[0]) begin
      w_found = 1'b1;
      w_win   = '0;
    end
`endif
  end

  // One-hot grant vector and operand slices of the candidate winner
  always_comb begin
    w_win_oh = '0;
    w_a      = '0;
    w_b      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PTR_W'(i) == w_win) begin
        w_win_oh[i] = 1'b1;
        w_a         = req_a[i*A_W +: A_W];
        w_b         = req_b[i*A_W +: A_W];
      end
    end
  end

  assign w_ptr_nxt = PTR_W'((int'(r_win) + 1) % NUM_REQ);

  // Scheduler FSM with all outputs registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_win       <= '0;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_add_valid <= 1'b0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rsp_valid <= '0;
          if (w_found) begin
            r_win       <= w_win;
            r_gnt       <= w_win_oh;
            r_add_a     <= w_a;
            r_add_b     <= w_b;
            r_add_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_add_valid <= 1'b0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          // Adder output is valid this cycle; grant vector doubles as the response mask
          r_rsp_data  <= add_c;
          r_rsp_valid <= r_gnt;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          r_rsp_valid <= '0;
          r_gnt       <= '0;
          r_busy      <= 1'b0;
`ifdef ADDER_RR_SCHED_PRIO0_EN
          if (r_win != '0) r_ptr <= w_ptr_nxt;
`else
          r_ptr <= w_ptr_nxt;
`endif
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign add_valid = r_add_valid;
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign busy      = r_busy;

endmodule
